// File: rtl/div_pkg.sv
// Shared types and default widths for the divide dispatch front end.
package div_pkg;

  localparam int DIV_DW = 8;
  localparam int DIV_TW = 4;

  // The dividend travels with the tag so a zero-divisor result can be rebuilt locally.
  typedef struct packed {
    logic [DIV_TW-1:0] tag;
    logic              div0;
    logic [DIV_DW-1:0] dividend;
  } tag_entry_t;

  typedef struct packed {
    logic [DIV_TW-1:0] tag;
    logic              div0;
    logic [DIV_DW-1:0] quotient;
    logic [DIV_DW-1:0] remainder;
  } rsp_entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} dd_state_t;

endpackage

// File: rtl/div_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty; DEPTH must be a power of 2.
module div_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           full_q, full_d, empty_q, empty_d;
  logic           do_push, do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (count_d == (AW+1)'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/div_dispatch.sv
// Credit-based dispatch/collect front end for the no-stall divide pipeline.
// Define DIV_DISPATCH_STATS_EN to add the stat_issued / stat_div0 counters.
module div_dispatch
  import div_pkg::*;
#(
  parameter int DATA_WIDTH     = DIV_DW,
  parameter int QUANTIZED_BITS = 10,
  parameter int TAG_WIDTH      = DIV_TW,
  parameter int MAX_INFLIGHT   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_dividend,
  input  logic [DATA_WIDTH-1:0] req_divisor,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  div_valid_in,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic                  div_valid_out,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_quotient,
  output logic [DATA_WIDTH-1:0] rsp_remainder,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_div0,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  err_underflow
`ifdef DIV_DISPATCH_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_div0
`endif
);

  localparam int              CW          = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CW-1:0]   MAX_CREDITS = CW'(MAX_INFLIGHT);
  localparam int              unused_quantized_bits = QUANTIZED_BITS;

  dd_state_t              state_q, state_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic                   ready_en_q, ready_en_d;
  logic                   div_valid_in_q, div_valid_in_d;
  logic [DATA_WIDTH-1:0]  dividend_q, dividend_d, divisor_q, divisor_d;
  logic                   err_underflow_q, err_underflow_d;
  tag_entry_t             tag_din, tag_head;
  rsp_entry_t             res_din, res_head;
  logic                   tag_full, tag_empty, res_full, res_empty;
  logic                   accept, tag_pop, rsp_pop;

  // ready_en_q keeps req_ready low while reset is applied and for the first edge after.
  assign req_ready = ready_en_q & (state_q == RUN) & (credits_q != '0) & ~tag_full;
  assign rsp_valid = ~res_empty;

  always_comb begin
    accept  = req_valid & req_ready;
    rsp_pop = rsp_valid & rsp_ready;
    tag_pop = div_valid_out & ~tag_empty;

    tag_din.tag      = req_tag;
    tag_din.div0     = (req_divisor == '0);
    tag_din.dividend = req_dividend;

    res_din.tag  = tag_head.tag;
    res_din.div0 = tag_head.div0;
    if (tag_head.div0) begin
      res_din.quotient  = {tag_head.dividend[DATA_WIDTH-1],
                           {(DATA_WIDTH-1){~tag_head.dividend[DATA_WIDTH-1]}}};
      res_din.remainder = tag_head.dividend;
    end else begin
      res_din.quotient  = div_quotient;
      res_din.remainder = div_remainder;
    end

    credits_d = credits_q;
    if (accept && !rsp_pop)      credits_d = credits_q - CW'(1);
    else if (!accept && rsp_pop) credits_d = credits_q + CW'(1);

    ready_en_d      = 1'b1;
    div_valid_in_d  = accept;
    dividend_d      = accept ? req_dividend : dividend_q;
    divisor_d       = accept ? req_divisor  : divisor_q;
    err_underflow_d = err_underflow_q | (div_valid_out & tag_empty);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (credits_q == MAX_CREDITS) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= RUN;
      credits_q       <= MAX_CREDITS;
      ready_en_q      <= 1'b0;
      div_valid_in_q  <= 1'b0;
      dividend_q      <= '0;
      divisor_q       <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      credits_q       <= credits_d;
      ready_en_q      <= ready_en_d;
      div_valid_in_q  <= div_valid_in_d;
      dividend_q      <= dividend_d;
      divisor_q       <= divisor_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  div_sync_fifo #(.T(tag_entry_t), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (accept),
    .din   (tag_din),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  div_sync_fifo #(.T(rsp_entry_t), .DEPTH(MAX_INFLIGHT)) u_res_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (tag_pop & ~res_full),
    .din   (res_din),
    .pop   (rsp_pop),
    .dout  (res_head),
    .full  (res_full),
    .empty (res_empty)
  );

  assign div_valid_in  = div_valid_in_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign rsp_quotient  = rsp_valid ? res_head.quotient  : '0;
  assign rsp_remainder = rsp_valid ? res_head.remainder : '0;
  assign rsp_tag       = rsp_valid ? res_head.tag       : '0;
  assign rsp_div0      = rsp_valid & res_head.div0;
  assign flush_done    = (state_q == DONE);
  assign err_underflow = err_underflow_q;

`ifdef DIV_DISPATCH_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d, stat_div0_q, stat_div0_d;

  always_comb begin
    stat_issued_d = stat_issued_q + 32'(accept);
    stat_div0_d   = stat_div0_q + 32'(accept & tag_din.div0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_issued_q <= '0;
      stat_div0_q   <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_div0_q   <= stat_div0_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_div0   = stat_div0_q;
`endif

endmodule

// File: tb/tb_div_dispatch.sv
// Scoreboard bench for div_dispatch with a behavioural 12-cycle signed divider.
module tb_div_dispatch;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [7:0]        req_dividend = '0;
  logic [7:0]        req_divisor = '0;
  logic [3:0]        req_tag = '0;
  logic              div_valid_in;
  logic signed [7:0] div_dividend, div_divisor;
  logic              div_valid_out;
  logic signed [7:0] div_quotient, div_remainder;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [7:0]        rsp_quotient, rsp_remainder;
  logic [3:0]        rsp_tag;
  logic              rsp_div0;
  logic              flush = 1'b0;
  logic              flush_done, err_underflow;
`ifdef DIV_DISPATCH_STATS_EN
  logic [31:0]       stat_issued, stat_div0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic [3:0] tag;
    logic       div0;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  div_dispatch #(
    .DATA_WIDTH     (8),
    .QUANTIZED_BITS (10),
    .TAG_WIDTH      (4),
    .MAX_INFLIGHT   (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_tag       (req_tag),
    .div_valid_in  (div_valid_in),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_valid_out (div_valid_out),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_tag       (rsp_tag),
    .rsp_div0      (rsp_div0),
    .flush         (flush),
    .flush_done    (flush_done),
    .err_underflow (err_underflow)
`ifdef DIV_DISPATCH_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_div0     (stat_div0)
`endif
  );

  // Divider model: no reset, so results issued before a DUT reset still arrive later.
  logic [11:0]       pv = '0;
  logic signed [7:0] pq [12];
  logic signed [7:0] pr [12];

  always @(posedge clock) begin
    for (int i = 11; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pq[i] <= pq[i-1];
      pr[i] <= pr[i-1];
    end
    pv[0] <= div_valid_in;
    if (div_divisor == 0) begin
      pq[0] <= 8'sh55;
      pr[0] <= 8'sh33;
    end else begin
      pq[0] <= div_dividend / div_divisor;
      pr[0] <= div_dividend % div_divisor;
    end
  end

  assign div_valid_out = pv[11];
  assign div_quotient  = pq[11];
  assign div_remainder = pr[11];

  // Monitor: samples 2 time units after the falling edge, pops the scoreboard on every handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset && rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got tag=%0d q=%0d r=%0d, required no response",
                   rsp_tag, $signed(rsp_quotient), $signed(rsp_remainder));
        end else begin
          e = exp_q.pop_front();
          if (rsp_quotient !== e.q || rsp_remainder !== e.r || rsp_tag !== e.tag || rsp_div0 !== e.div0) begin
            errors++;
            $display("FAIL rsp_data: got tag=%0d q=%0d r=%0d div0=%0d, required tag=%0d q=%0d r=%0d div0=%0d",
                     rsp_tag, $signed(rsp_quotient), $signed(rsp_remainder), rsp_div0,
                     e.tag, $signed(e.q), $signed(e.r), e.div0);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                       input logic [7:0] eq, input logic [7:0] er, input logic ed);
    int n;
    exp_t e;
    req_valid = 1'b1;
    req_dividend = a;
    req_divisor = b;
    req_tag = t;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got req_ready=0 for %0d cycles, required 1", n);
    end else begin
      e.q = eq;
      e.r = er;
      e.tag = t;
      e.div0 = ed;
      exp_q.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [63:0] all_outputs();
    return {22'd0, req_ready, div_valid_in, div_dividend, div_divisor, rsp_valid, rsp_quotient,
            rsp_remainder, rsp_tag, rsp_div0, flush_done, err_underflow};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] t4_a [5] = '{8'd20, 8'd21, 8'd22, 8'd23, 8'd24};
  logic [7:0] t4_q [5] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd6};
  logic [7:0] t4_r [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

  initial begin
    int n, cnt, last_pop, done_at, pulses, ready_low;
    logic [7:0] v;

    repeat (2) @(negedge clock);
    chk("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b1;

    // 1: single request; divider strobe next cycle, response 13 falling edges after accept
    issue(8'd94, 8'd10, 4'd3, 8'd9, 8'd4, 1'b0);
    req_valid = 1'b0;
    chk("t1_div_issue", {div_valid_in, div_dividend, div_divisor}, {1'b1, 8'd94, 8'd10});
    @(negedge clock);
    chk("t1_valid_in_pulse", div_valid_in, 1'b0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("t1_latency", n, 13);
    // 8'hC2 is -62 signed: -62/10 truncates to -6 remainder -2
    issue(8'hC2, 8'd10, 4'd4, 8'hFA, 8'hFE, 1'b0);
    idle(16);

    // 2: fill all 16 credits with the consumer stalled; dividend 3i+1 over 3 gives q=i r=1
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = 8'(3 * i + 1);
      issue(v, 8'd3, 4'(i), 8'(i), 8'd1, 1'b0);
    end
    chk("t2_ready_drop", req_ready, 1'b0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (req_ready) cnt++;
    end
    chk("t2_no_overissue", cnt, 0);
    idle(16);
    rsp_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (rsp_valid) cnt++;
      @(negedge clock);
    end
    chk("t2_one_per_cycle", cnt, 16);
    chk("t2_fifo_empty", rsp_valid, 1'b0);

    // 3: divide by zero saturates from the dividend sign and returns the dividend
    issue(8'h9C, 8'd0, 4'd5, 8'h80, 8'h9C, 1'b1);
    issue(8'd100, 8'd0, 4'd6, 8'h7F, 8'd100, 1'b1);
    issue(8'd0, 8'd0, 4'd7, 8'h7F, 8'd0, 1'b1);
    idle(16);

    // 4: flush with 5 in flight
    for (int i = 0; i < 5; i++) issue(t4_a[i], 8'd4, 4'(8 + i), t4_q[i], t4_r[i], 1'b0);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clock);
    chk("t4_ready_off", req_ready, 1'b0);
    last_pop = -1;
    done_at = -1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid && rsp_ready) last_pop = k;
      if (flush_done) begin
        pulses++;
        if (done_at < 0) done_at = k;
        flush = 1'b0;
      end
      @(negedge clock);
    end
    // the sampled pop commits on the next edge; DONE is entered one edge later
    chk("t4_done_timing", 64'(done_at), 64'(last_pop + 2));
    chk("t4_done_pulse", pulses, 1);
    chk("t4_ready_back", req_ready, 1'b1);
`ifdef DIV_DISPATCH_STATS_EN
    chk("stat_issued_pre", stat_issued, 32'd26);
    chk("stat_div0_pre", stat_div0, 32'd3);
`endif

    // 5: reset with 4 requests in flight; their late results must be dropped
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(8'd40, 8'd7, 4'(i), 8'd5, 8'd5, 1'b0);
    req_valid = 1'b0;
    @(negedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    #1 chk("t5_reset_outputs", all_outputs(), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("t5_err_clear", err_underflow, 1'b0);
    repeat (20) @(negedge clock);
    chk("t5_err_set", err_underflow, 1'b1);
    chk("t5_nothing_pushed", rsp_valid, 1'b0);

    // 6: continuous accept with pops once the pipeline fills; credits must never run out
    rsp_ready = 1'b1;
    ready_low = 0;
    for (int i = 0; i < 50; i++) begin
      if (!req_ready) ready_low++;
      issue(8'(i), 8'd5, 4'(i), 8'(i / 5), 8'(i % 5), 1'b0);
    end
    chk("t6_ready_held", ready_low, 0);
    idle(20);
`ifdef DIV_DISPATCH_STATS_EN
    chk("stat_issued", stat_issued, 32'd50);
    chk("stat_div0", stat_div0, 32'd0);
`endif
    chk("all_responses_seen", exp_q.size(), 0);
    chk("err_sticky", err_underflow, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
